// File: rtl/riscv_lsu_ctrl_if.sv
// riscv_lsu_ctrl_if: bundle of execute-stage request, data-memory bus and
// response signals for the load/store sequencer.
//   slave  : the LSU controller view (drives req_ready/stall, bus request
//            outputs and the response).
//   master : the environment view (execute stage plus memory bus).
interface riscv_lsu_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: load/store sequencer between execute stage and data bus.
// Accepts one access in IDLE, runs a req/gnt/rvalid handshake, steers store
// byte lanes, extracts and extends load data, flags misaligned/illegal
// accesses and holds the core via stall until the access completes.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   bus      : riscv_lsu_ctrl_if.slave (request, memory bus, response)
// Optional feature macro: LSU_TIMEOUT_EN aborts an access that spends
// TIMEOUT_CYCLES cycles in REQ+WAIT, completing it with resp_err=1.
module riscv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  riscv_lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  // Request decode: error detection and store lane steering.
  logic        bad_req;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  always_comb begin
    bad_req  = 1'b0;
    st_wdata = '0;
    st_be    = 4'b1111;
    if (bus.req_we) begin
      case (bus.req_funct3)
        3'b000: begin
          st_wdata = {4{bus.req_wdata[7:0]}};
          st_be    = 4'b0001 << bus.req_addr[1:0];
        end
        3'b001: begin
          st_wdata = {2{bus.req_wdata[15:0]}};
          st_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
          bad_req  = bus.req_addr[0];
        end
        3'b010: begin
          st_wdata = bus.req_wdata;
          bad_req  = |bus.req_addr[1:0];
        end
        default: bad_req = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b100: bad_req = 1'b0;
        3'b001, 3'b101: bad_req = bus.req_addr[0];
        3'b010:         bad_req = |bus.req_addr[1:0];
        default:        bad_req = 1'b1;
      endcase
    end
  end

  // Load lane selection and extension from the latched funct3/offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;
  logic          timeout;
  // Counter holds cycles already spent in REQ+WAIT; leaving on the cycle
  // where it equals TIMEOUT_CYCLES-1 makes DONE land TIMEOUT_CYCLES after
  // REQ entry.
  assign timeout = (to_cnt == T_LAST);
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      lo_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q <= bus.req_we;
            f3_q <= bus.req_funct3;
            lo_q <= bus.req_addr[1:0];
            if (bad_req) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state       <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q <= st_wdata;
              mem_be_q    <= st_be;
`ifdef LSU_TIMEOUT_EN
              to_cnt      <= '0;
`endif
            end
          end
        end
        REQ: begin
`ifdef LSU_TIMEOUT_EN
          to_cnt <= to_cnt + 1'b1;
`endif
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (we_q) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
            end else if (bus.mem_rvalid) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= ld_data;
            end else begin
              state <= WAIT;
            end
          end else if (timeout) begin
            state        <= DONE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        WAIT: begin
`ifdef LSU_TIMEOUT_EN
          to_cnt <= to_cnt + 1'b1;
`endif
          if (bus.mem_rvalid) begin
            state        <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= ld_data;
          end else if (timeout) begin
            state        <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.stall      = ~rst & (((state == IDLE) & bus.req_valid) |
                                  (state == REQ) | (state == WAIT));
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb_riscv_lsu_ctrl: self-checking bench for riscv_lsu_ctrl. Directed
// scenarios plus randomized accesses compared against an arithmetic model
// of lane steering, extension, error rules and latency.
module tb_riscv_lsu_ctrl;
`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  riscv_lsu_ctrl_if b ();
  riscv_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  typedef struct {
    int lat; int stall_n; bit req_seen; bit stable;
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we;
    logic err; logic [31:0] rdata;
    logic post_valid; logic post_req; logic post_err; logic [31:0] post_rdata;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic bit m_err(bit we, logic [2:0] f, logic [31:0] a);
    int sz;
    if (we && f > 3'd2) return 1'b1;
    if (!we && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
    sz = 1 << f[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(bit we, logic [2:0] f, logic [31:0] a);
    int sz;
    if (!we) return 4'hF;
    sz = 1 << f[1:0];
    return 4'((((1 << sz) - 1) << (a % 4)) & 15);
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f, logic [31:0] w);
    if (f == 3'd0) return (w & 32'hFF) * 32'h01010101;
    if (f == 3'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a, logic [31:0] d);
    logic [31:0] v;
    v = d >> ((a % 4) * 8);
    case (f)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic int m_lat(bit we, logic [2:0] f, logic [31:0] a, int g, int r);
    if (m_err(we, f, a)) return 1;
    if (we) return g + 2;
    return g + r + 2;
  endfunction

  // Drives one access and acts as the memory bus: gnt after g cycles of
  // mem_req, rvalid r cycles after gnt (loads). Records what it observed.
  task automatic run_access(input bit we, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] w, input int g, input int r,
                            input logic [31:0] rd, input bit hold, output obs_t o);
    int req_cnt;
    int gcyc;
    o = '{lat: -1, stall_n: 0, req_seen: 0, stable: 1, addr: 0, wdata: 0, be: 0,
          we: 0, err: 0, rdata: 0, post_valid: 0, post_req: 0, post_err: 0,
          post_rdata: 0};
    req_cnt = 0;
    gcyc = -1;
    @(posedge clk); #1;
    b.req_valid = 1'b1; b.req_we = we; b.req_funct3 = f;
    b.req_addr = a; b.req_wdata = w;
    @(negedge clk);
    if (b.stall) o.stall_n++;
    for (int cyc = 1; cyc < 400 && o.lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (hold) begin
        b.req_we = 1'($urandom); b.req_funct3 = 3'($urandom);
        b.req_addr = $urandom; b.req_wdata = $urandom;
      end else begin
        b.req_valid = 1'b0;
      end
      b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0; b.mem_rdata = $urandom;
      if (b.mem_req) begin
        if (!o.req_seen) begin
          o.req_seen = 1; o.addr = b.mem_addr; o.wdata = b.mem_wdata;
          o.be = b.mem_be; o.we = b.mem_we;
        end else if (b.mem_addr !== o.addr || b.mem_be !== o.be ||
                     b.mem_wdata !== o.wdata || b.mem_we !== o.we) begin
          o.stable = 0;
        end
        if (req_cnt == g) begin b.mem_gnt = 1'b1; gcyc = cyc; end
        req_cnt++;
      end
      if (!we && gcyc >= 0 && cyc == gcyc + r) begin
        b.mem_rvalid = 1'b1; b.mem_rdata = rd;
      end
      @(negedge clk);
      if (b.stall) o.stall_n++;
      if (b.resp_valid) begin
        o.lat = cyc; o.err = b.resp_err; o.rdata = b.resp_rdata;
      end
    end
    @(posedge clk); #1;
    b.req_valid = 1'b0; b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
    @(negedge clk);
    o.post_valid = b.resp_valid; o.post_req = b.mem_req;
    o.post_err = b.resp_err; o.post_rdata = b.resp_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    b.req_valid = 1'b1; b.req_we = 1'b0; b.req_funct3 = 3'd2;
    b.req_addr = 32'h40; b.req_wdata = '0;
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0; b.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (b.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", b.req_ready); end
    total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", b.stall); end
    @(posedge clk); #1;
    rst = 1'b0; b.req_valid = 1'b0;
    @(negedge clk);
    total++; if (b.req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", b.req_ready); end
    total++;
    if ({b.mem_req, b.mem_we, b.resp_valid, b.resp_err, b.stall} !== 5'b0 ||
        b.mem_addr !== 32'h0 || b.mem_wdata !== 32'h0 || b.resp_rdata !== 32'h0 ||
        b.mem_be !== 4'b0000) begin
      bad++;
      $display("FAIL post_rst_zero: req=%b we=%b rv=%b err=%b stall=%b addr=%h wd=%h rd=%h be=%b want all 0",
               b.mem_req, b.mem_we, b.resp_valid, b.resp_err, b.stall, b.mem_addr,
               b.mem_wdata, b.resp_rdata, b.mem_be);
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_access(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, o);
    total++; if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.wdata !== 32'hDEADBEEF || o.we !== 1'b1) begin
      bad++; $display("FAIL sw_bus: addr=%h be=%b wd=%h we=%b want 100 1111 deadbeef 1", o.addr, o.be, o.wdata, o.we); end
    total++; if (o.lat !== 2 || o.err !== 1'b0 || o.stall_n !== 2) begin
      bad++; $display("FAIL sw_resp: lat=%0d err=%b stall=%0d want 2 0 2", o.lat, o.err, o.stall_n); end
    run_access(1, 3'd0, 32'h203, 32'h000000A5, 0, 0, 0, 0, o);
    total++; if (o.addr !== 32'h200 || o.be !== 4'b1000 || o.wdata !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL sb_bus: addr=%h be=%b wd=%h want 200 1000 a5a5a5a5", o.addr, o.be, o.wdata); end
    run_access(1, 3'd1, 32'h402, 32'h1234BEEF, 1, 0, 0, 0, o);
    total++; if (o.be !== 4'b1100 || o.wdata !== 32'hBEEFBEEF || o.lat !== 3) begin
      bad++; $display("FAIL sh_bus: be=%b wd=%h lat=%0d want 1100 beefbeef 3", o.be, o.wdata, o.lat); end
  endtask

  task automatic test_load();
    obs_t o;
    run_access(0, 3'd0, 32'h302, 32'h0, 0, 2, 32'h12F03456, 0, o);
    total++; if (o.rdata !== 32'hFFFFFFF0 || o.lat !== 4 || o.stall_n !== 4) begin
      bad++; $display("FAIL lb: rd=%h lat=%0d stall=%0d want fffffff0 4 4", o.rdata, o.lat, o.stall_n); end
    total++; if (o.be !== 4'b1111 || o.we !== 1'b0 || o.addr !== 32'h300) begin
      bad++; $display("FAIL lb_bus: be=%b we=%b addr=%h want 1111 0 300", o.be, o.we, o.addr); end
    run_access(0, 3'd4, 32'h302, 32'h0, 0, 2, 32'h12F03456, 0, o);
    total++; if (o.rdata !== 32'h000000F0) begin
      bad++; $display("FAIL lbu: rd=%h want 000000f0", o.rdata); end
    run_access(0, 3'd2, 32'h80, 32'h0, 0, 0, 32'hCAFEF00D, 0, o);
    total++; if (o.rdata !== 32'hCAFEF00D || o.lat !== 2) begin
      bad++; $display("FAIL lw_same_cycle: rd=%h lat=%0d want cafef00d 2", o.rdata, o.lat); end
  endtask

  task automatic test_error();
    obs_t o;
    run_access(0, 3'd1, 32'h101, 32'h0, 0, 0, 0, 0, o);
    total++; if (o.lat !== 1 || o.err !== 1'b1 || o.req_seen !== 1'b0 || o.rdata !== 32'h0) begin
      bad++; $display("FAIL lh_misalign: lat=%0d err=%b req=%b rd=%h want 1 1 0 0", o.lat, o.err, o.req_seen, o.rdata); end
    run_access(0, 3'd3, 32'h100, 32'h0, 0, 0, 0, 0, o);
    total++; if (o.lat !== 1 || o.err !== 1'b1 || o.req_seen !== 1'b0) begin
      bad++; $display("FAIL ld_illegal: lat=%0d err=%b req=%b want 1 1 0", o.lat, o.err, o.req_seen); end
    run_access(1, 3'd3, 32'h100, 32'h0, 0, 0, 0, 0, o);
    total++; if (o.lat !== 1 || o.err !== 1'b1 || o.req_seen !== 1'b0) begin
      bad++; $display("FAIL st_illegal: lat=%0d err=%b req=%b want 1 1 0", o.lat, o.err, o.req_seen); end
  endtask

  task automatic test_gnt_stall();
    obs_t o;
    run_access(1, 3'd0, 32'h55, 32'h3C, 5, 0, 0, 0, o);
    total++; if (o.stable !== 1'b1 || o.req_seen !== 1'b1 || o.lat !== 7 || o.stall_n !== 7) begin
      bad++; $display("FAIL gnt_hold: stable=%b seen=%b lat=%0d stall=%0d want 1 1 7 7", o.stable, o.req_seen, o.lat, o.stall_n); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    b.req_valid = 1'b1; b.req_we = 1'b0; b.req_funct3 = 3'd2; b.req_addr = 32'h40;
    @(posedge clk); #1;
    b.req_valid = 1'b0; b.mem_gnt = 1'b1;
    @(posedge clk); #1;
    b.mem_gnt = 1'b0;
    total++; if (b.mem_req !== 1'b0 || b.stall !== 1'b1) begin
      bad++; $display("FAIL wait_state: req=%b stall=%b want 0 1", b.mem_req, b.stall); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h11223344;
    @(negedge clk);
    total++; if (b.req_ready !== 1'b1 || b.resp_valid !== 1'b0 || b.stall !== 1'b0 || b.mem_req !== 1'b0) begin
      bad++; $display("FAIL rst_mid: ready=%b rv=%b stall=%b req=%b want 1 0 0 0", b.req_ready, b.resp_valid, b.stall, b.mem_req); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      b.mem_rvalid = 1'b0;
      @(negedge clk);
      total++; if (b.resp_valid !== 1'b0) begin
        bad++; $display("FAIL stale_rvalid: rv=%b want 0 (cycle %0d)", b.resp_valid, i); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_access(i[0], 3'd2, 32'h1000 + 32'(i * 4), 32'h5A5A0000 + 32'(i), 0, 1, 32'hA0B0C0D0, 1, o);
      total++;
      if (o.lat !== m_lat(i[0], 3'd2, 0, 0, 1) || o.post_valid !== 1'b0 || o.post_req !== 1'b0 ||
          o.addr !== 32'h1000 + 32'(i * 4) || o.rdata !== (i[0] ? 32'h0 : 32'hA0B0C0D0)) begin
        bad++;
        $display("FAIL b2b_%0d: lat=%0d pv=%b preq=%b addr=%h rd=%h", i, o.lat, o.post_valid, o.post_req, o.addr, o.rdata);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit we; logic [2:0] f; logic [31:0] a, w, rd, ex_rd; int g, r, sz;
    bit e;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom);
      f  = we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      sz = 1 << f[1:0];
      a  = $urandom & ~32'(sz - 1);
      if ($urandom_range(0, 6) == 0) begin f = 3'($urandom); a = $urandom; end
      w = $urandom; rd = $urandom;
      g = $urandom_range(0, 3); r = $urandom_range(0, 3);
      run_access(we, f, a, w, g, r, rd, 1'($urandom), o);
      e = m_err(we, f, a);
      ex_rd = (e || we) ? 32'h0 : m_load(f, a, rd);
      total++;
      if (o.lat !== m_lat(we, f, a, g, r) || o.err !== e || o.rdata !== ex_rd ||
          o.stall_n !== o.lat || o.post_valid !== 1'b0 || o.post_err !== e ||
          o.post_rdata !== ex_rd) begin
        bad++;
        $display("FAIL rnd_resp_%0d: we=%b f=%0d a=%h lat=%0d/%0d err=%b/%b rd=%h/%h stall=%0d pv=%b prd=%h",
                 n, we, f, a, o.lat, m_lat(we, f, a, g, r), o.err, e, o.rdata, ex_rd,
                 o.stall_n, o.post_valid, o.post_rdata);
      end
      total++;
      if (o.req_seen !== !e ||
          (!e && (o.addr !== (a & ~32'h3) || o.be !== m_be(we, f, a) || o.we !== we ||
                  o.stable !== 1'b1 || (we && o.wdata !== m_wdata(f, w))))) begin
        bad++;
        $display("FAIL rnd_bus_%0d: seen=%b addr=%h be=%b/%b we=%b wd=%h/%h stable=%b",
                 n, o.req_seen, o.addr, o.be, m_be(we, f, a), o.we, o.wdata, m_wdata(f, w), o.stable);
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_access(1, 3'd2, 32'h700, 32'h1, 100000, 0, 0, 0, o);
    total++; if (o.lat !== int'(TO) + 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.post_req !== 1'b0) begin
      bad++; $display("FAIL timeout_req: lat=%0d err=%b rd=%h preq=%b want %0d 1 0 0", o.lat, o.err, o.rdata, o.post_req, TO + 1); end
    run_access(0, 3'd2, 32'h700, 32'h0, 0, 100000, 32'h9, 0, o);
    total++; if (o.lat !== int'(TO) + 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      bad++; $display("FAIL timeout_wait: lat=%0d err=%b rd=%h want %0d 1 0", o.lat, o.err, o.rdata, TO + 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_load();
    test_error();
    test_gnt_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
